// File: rtl/cat_rec_apb_sequencer.sv
// APB control stage in front of the neuron calculator: pixel-memory access, BIAS/STATUS/CTRL
// registers, and a run sequencer that streams all pixels and latches the cat decision.
module cat_rec_apb_sequencer #(
   parameter int Amba_Word       = 24,
   parameter int Amba_Addr_Depth = 12,
   parameter int Num_Pixels      = 3072,
   parameter int Mem_Latency     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [Amba_Addr_Depth-1:0] PADDR,
   input  logic [Amba_Word-1:0]       PWDATA,
   output logic [Amba_Word-1:0]       PRDATA,
   output logic [Amba_Addr_Depth-1:0] mem_addr,
   output logic                       mem_wr_en,
   output logic                       mem_rd_en,
   output logic [Amba_Word-1:0]       mem_wdata,
   input  logic [Amba_Word-1:0]       mem_rdata,
   output logic                       calc_clr,
   output logic                       calc_en,
   output logic                       calc_get_result,
   output logic [Amba_Word-1:0]       calc_bias,
   input  logic                       calc_out,
   output logic                       CatRecOut,
   output logic                       done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLR    = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;

   localparam logic [Amba_Addr_Depth-1:0] ADDR_CTRL   = {Amba_Addr_Depth{1'b1}};
   localparam logic [Amba_Addr_Depth-1:0] ADDR_STATUS = {{(Amba_Addr_Depth-1){1'b1}}, 1'b0};
   localparam logic [Amba_Addr_Depth-1:0] ADDR_BIAS   = {{(Amba_Addr_Depth-2){1'b1}}, 2'b01};
   localparam logic [Amba_Addr_Depth-1:0] LAST_PIX    = Amba_Addr_Depth'(Num_Pixels - 1);
   localparam logic [Amba_Addr_Depth-1:0] LAST_DRAIN  = Amba_Addr_Depth'(Mem_Latency - 1);

   logic [2:0]                 state;
   logic [Amba_Addr_Depth-1:0] cnt;
   logic [Mem_Latency-1:0]     en_pipe;
   logic [Amba_Word-1:0]       bias;
   logic                       done_sticky;

   logic idle, seq_rd, apb_wr, apb_rd, is_pixel;
   logic pix_wr, pix_rd_setup, bias_wr, start;

   assign idle         = (state == S_IDLE);
   assign seq_rd       = (state == S_STREAM);
   assign apb_wr       = PSEL & PENABLE & PWRITE;
   assign apb_rd       = PSEL & PENABLE & ~PWRITE;
   assign is_pixel     = (PADDR <= LAST_PIX);
   // Every APB side effect is gated by idle so a running image cannot be disturbed.
   assign pix_wr       = apb_wr & is_pixel & idle;
   assign pix_rd_setup = PSEL & ~PENABLE & ~PWRITE & is_pixel & idle;
   assign bias_wr      = apb_wr & (PADDR == ADDR_BIAS) & idle;
   assign start        = apb_wr & (PADDR == ADDR_CTRL) & PWDATA[0] & idle;

   assign mem_rd_en       = seq_rd | pix_rd_setup;
   assign mem_wr_en       = pix_wr;
   assign mem_wdata       = pix_wr ? PWDATA : '0;
   assign calc_clr        = (state == S_CLR);
   assign calc_get_result = (state == S_RESULT);
   assign calc_en         = en_pipe[Mem_Latency-1];
   assign calc_bias       = bias;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      mem_addr = '0;
      if (seq_rd)
         mem_addr = cnt;
      else if (pix_wr || pix_rd_setup)
         mem_addr = PADDR;
   end

   always_comb begin
      PRDATA = '0;
      if (apb_rd) begin
         if (PADDR == ADDR_BIAS)
            PRDATA = bias;
         else if (PADDR == ADDR_STATUS)
            PRDATA = {{(Amba_Word-3){1'b0}}, CatRecOut, done_sticky, ~idle};
         else if (is_pixel && idle && Mem_Latency == 1)
            PRDATA = mem_rdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         en_pipe     <= '0;
         bias        <= '0;
         CatRecOut   <= 1'b0;
         done        <= 1'b0;
         done_sticky <= 1'b0;
      end else begin
         // calc_en trails the sequencer reads by exactly the memory latency.
         en_pipe <= (en_pipe << 1) | Mem_Latency'(seq_rd);
         done    <= 1'b0;
         if (bias_wr)
            bias <= PWDATA;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_CLR;
                  done_sticky <= 1'b0;
               end
            end
            S_CLR: begin
               state <= S_STREAM;
               cnt   <= '0;
            end
            S_STREAM: begin
               if (cnt == LAST_PIX) begin
                  state <= S_DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (cnt == LAST_DRAIN)
                  state <= S_RESULT;
               else
                  cnt <= cnt + 1'b1;
            end
            S_RESULT: begin
               CatRecOut   <= calc_out;
               done        <= 1'b1;
               done_sticky <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cat_rec_apb_sequencer.sv
// Bench for cat_rec_apb_sequencer: instance a (3072 pixels, latency 1) for APB/reset checks,
// instance b (4 pixels, latency 2) for run timing, busy protection and back-to-back runs.
module tb_cat_rec_apb_sequencer;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        psel_a, psel_b, penable, pwrite;
   logic [11:0] paddr;
   logic [23:0] pwdata;

   logic [23:0] a_prdata, a_mem_wdata, a_mem_rdata, a_calc_bias;
   logic [11:0] a_mem_addr;
   logic        a_mem_wr_en, a_mem_rd_en, a_calc_clr, a_calc_en, a_calc_get_result;
   logic        a_calc_out, a_cat, a_done;

   logic [23:0] b_prdata, b_mem_wdata, b_mem_rdata, b_calc_bias;
   logic [11:0] b_mem_addr;
   logic        b_mem_wr_en, b_mem_rd_en, b_calc_clr, b_calc_en, b_calc_get_result;
   logic        b_calc_out, b_cat, b_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [23:0] rd_q[$];
   logic [11:0] addr_q[$];
   logic        cat_q[$];

   logic        acc_wr_en, setup_rd_en;
   logic [11:0] acc_addr, setup_addr;
   logic [23:0] acc_wdata;
   int          acc_cyc;

   int b_clr_cnt = 0, b_clr_cyc = -1, b_rd_cnt = 0, b_first_rd = -1;
   int b_en_cnt = 0, b_first_en = -1, b_gr_cnt = 0, b_done_cnt = 0, b_done_cyc = -1, b_wr_cnt = 0;

   cat_rec_apb_sequencer #(.Amba_Word(24), .Amba_Addr_Depth(12), .Num_Pixels(3072), .Mem_Latency(1)) dut_a (
      .clk(clk), .rst(rst_a), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
      .PWDATA(pwdata), .PRDATA(a_prdata), .mem_addr(a_mem_addr), .mem_wr_en(a_mem_wr_en),
      .mem_rd_en(a_mem_rd_en), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .calc_clr(a_calc_clr),
      .calc_en(a_calc_en), .calc_get_result(a_calc_get_result), .calc_bias(a_calc_bias),
      .calc_out(a_calc_out), .CatRecOut(a_cat), .done(a_done));

   cat_rec_apb_sequencer #(.Amba_Word(24), .Amba_Addr_Depth(12), .Num_Pixels(4), .Mem_Latency(2)) dut_b (
      .clk(clk), .rst(rst_b), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
      .PWDATA(pwdata), .PRDATA(b_prdata), .mem_addr(b_mem_addr), .mem_wr_en(b_mem_wr_en),
      .mem_rd_en(b_mem_rd_en), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .calc_clr(b_calc_clr),
      .calc_en(b_calc_en), .calc_get_result(b_calc_get_result), .calc_bias(b_calc_bias),
      .calc_out(b_calc_out), .CatRecOut(b_cat), .done(b_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-cycle-latency pixel memory behind instance a.
   logic [23:0] mem_a [0:4095];
   always @(posedge clk) begin
      if (a_mem_wr_en) mem_a[a_mem_addr] <= a_mem_wdata;
      if (a_mem_rd_en) a_mem_rdata <= mem_a[a_mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input bit which, input logic [11:0] addr, input logic [23:0] data);
      psel_a = !which; psel_b = which; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(negedge clk);
      penable = 1'b1;
      #1;
      acc_wr_en = which ? b_mem_wr_en : a_mem_wr_en;
      acc_addr  = which ? b_mem_addr  : a_mem_addr;
      acc_wdata = which ? b_mem_wdata : a_mem_wdata;
      acc_cyc   = cyc;
      @(negedge clk);
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   // Expected read data must already be queued in rd_q by the caller.
   task automatic apb_read(input bit which, input logic [11:0] addr, input string tag);
      logic [23:0] obs;
      psel_a = !which; psel_b = which; penable = 1'b0; pwrite = 1'b0; paddr = addr; pwdata = '0;
      #1;
      setup_rd_en = which ? b_mem_rd_en : a_mem_rd_en;
      setup_addr  = which ? b_mem_addr  : a_mem_addr;
      @(negedge clk);
      penable = 1'b1;
      #1;
      obs = which ? b_prdata : a_prdata;
      check(tag, {8'h0, obs}, {8'h0, rd_q.pop_front()});
      @(negedge clk);
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   // Event monitor for instance b, sampled mid-low-phase.
   always @(negedge clk) begin
      #2;
      if (b_calc_clr) begin b_clr_cnt++; b_clr_cyc = cyc; end
      if (b_mem_rd_en) begin
         if (b_first_rd < 0) b_first_rd = cyc;
         if (addr_q.size() != 0) check("b_stream_addr", {20'h0, b_mem_addr}, {20'h0, addr_q.pop_front()});
         b_rd_cnt++;
      end
      if (b_calc_en) begin
         if (b_first_en < 0) b_first_en = cyc;
         b_en_cnt++;
      end
      if (b_calc_get_result) b_gr_cnt++;
      if (b_mem_wr_en) b_wr_cnt++;
      if (b_done) begin
         b_done_cnt++;
         b_done_cyc = cyc;
         if (cat_q.size() != 0) check("b_cat_at_done", {31'h0, b_cat}, {31'h0, cat_q.pop_front()});
      end
   end

   initial begin
      int  start_cyc;
      bit  found;
      rst_a = 1'b1; rst_b = 1'b1;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      a_calc_out = 1'b0; b_calc_out = 1'b0; b_mem_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ctrl_outs", {25'h0, a_mem_rd_en, a_mem_wr_en, a_calc_clr, a_calc_en, a_calc_get_result, a_cat, a_done}, 0);
      check("rst_prdata", {8'h0, a_prdata}, 0);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // Pixel write then read-back through the latency-1 memory.
      apb_write(1'b0, 12'd5, 24'h00ABCD);
      check("pix_wr_en", {31'h0, acc_wr_en}, 1);
      check("pix_wr_addr", {20'h0, acc_addr}, 5);
      check("pix_wr_data", {8'h0, acc_wdata}, 32'h00ABCD);
      rd_q.push_back(24'h00ABCD);
      apb_read(1'b0, 12'd5, "pix_rd_data");
      check("pix_rd_setup_en", {31'h0, setup_rd_en}, 1);
      check("pix_rd_setup_addr", {20'h0, setup_addr}, 5);

      // BIAS round trip, unmapped and write-only reads, idle STATUS.
      apb_write(1'b0, 12'hFFD, 24'h123456);
      rd_q.push_back(24'h123456);
      apb_read(1'b0, 12'hFFD, "bias_rd");
      check("bias_out", {8'h0, a_calc_bias}, 32'h123456);
      rd_q.push_back(24'h0);
      apb_read(1'b0, 12'hFFC, "unmapped_rd");
      rd_q.push_back(24'h0);
      apb_read(1'b0, 12'hFFF, "ctrl_rd");
      rd_q.push_back(24'h0);
      apb_read(1'b0, 12'hFFE, "status_idle");

      // Reset in the middle of STREAM on instance a.
      apb_write(1'b0, 12'hFFF, 24'h1);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #2;
         if (a_mem_rd_en && a_mem_addr == 12'd100) begin found = 1'b1; break; end
      end
      check("reach_cnt100", {31'h0, found}, 1);
      rst_a = 1'b1;
      #1;
      check("midrun_rst_outs", {25'h0, a_mem_rd_en, a_mem_wr_en, a_calc_clr, a_calc_en, a_calc_get_result, a_cat, a_done}, 0);
      check("midrun_rst_addr", {20'h0, a_mem_addr}, 0);
      check("midrun_rst_bias", {8'h0, a_calc_bias}, 0);
      @(negedge clk);
      rst_a = 1'b0;
      rd_q.push_back(24'h0);
      apb_read(1'b0, 12'hFFE, "status_after_rst");

      // Fresh full-length run on instance a.
      a_calc_out = 1'b1;
      apb_write(1'b0, 12'hFFF, 24'h1);
      start_cyc = acc_cyc;
      found = 1'b0;
      for (int i = 0; i < 3200; i++) begin
         #2;
         if (a_done) begin found = 1'b1; break; end
         @(negedge clk);
      end
      check("a_done_seen", {31'h0, found}, 1);
      check("a_run_length", cyc - start_cyc, 3076);
      @(negedge clk);
      rd_q.push_back(24'h6);
      apb_read(1'b0, 12'hFFE, "a_status_after_run");

      // Instance b: short run, busy protection.
      apb_write(1'b1, 12'hFFD, 24'h000777);
      b_calc_out = 1'b1;
      cat_q.push_back(1'b1);
      for (int i = 0; i < 4; i++) addr_q.push_back(12'(i));
      apb_write(1'b1, 12'hFFF, 24'h1);
      start_cyc = acc_cyc;
      apb_write(1'b1, 12'd0, 24'h00BEEF);
      check("busy_pix_wr_en", {31'h0, acc_wr_en}, 0);
      apb_write(1'b1, 12'hFFF, 24'h1);
      apb_write(1'b1, 12'hFFD, 24'h0000AA);
      rd_q.push_back(24'h0);
      apb_read(1'b1, 12'd1, "busy_pix_rd");
      for (int i = 0; i < 50 && b_done_cnt < 1; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("b_clr_cnt", b_clr_cnt, 1);
      check("b_clr_cyc", b_clr_cyc - start_cyc, 1);
      check("b_first_rd", b_first_rd - start_cyc, 2);
      check("b_rd_cnt", b_rd_cnt, 4);
      check("b_first_en", b_first_en - start_cyc, 4);
      check("b_en_cnt", b_en_cnt, 4);
      check("b_gr_cnt", b_gr_cnt, 1);
      check("b_done_cyc", b_done_cyc - start_cyc, 9);
      check("b_done_cnt_run1", b_done_cnt, 1);
      check("b_wr_cnt", b_wr_cnt, 0);
      check("b_addr_q_empty", addr_q.size(), 0);
      rd_q.push_back(24'h6);
      apb_read(1'b1, 12'hFFE, "b_status_run1");
      rd_q.push_back(24'h000777);
      apb_read(1'b1, 12'hFFD, "b_bias_kept");
      check("b_bias_out", {8'h0, b_calc_bias}, 32'h000777);

      // Back-to-back second run with the opposite decision.
      b_calc_out = 1'b0;
      cat_q.push_back(1'b0);
      for (int i = 0; i < 4; i++) addr_q.push_back(12'(i));
      apb_write(1'b1, 12'hFFF, 24'h1);
      for (int i = 0; i < 50 && b_done_cnt < 2; i++) @(negedge clk);
      repeat (15) @(negedge clk);
      check("b_done_cnt_total", b_done_cnt, 2);
      check("b_cat_run2", {31'h0, b_cat}, 0);
      check("b_en_cnt_total", b_en_cnt, 8);
      rd_q.push_back(24'h2);
      apb_read(1'b1, 12'hFFE, "b_status_run2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
